// File: rtl/rojobot_motion_sequencer.sv
// Command-driven RojoBot wheel sequencer: runs a queued motion for a number of
// left-wheel steps, then stops on completion, abort or stall and pulses done.
module rojobot_motion_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_steps,
    input  logic       abort,
    input  logic [7:0] left_pos,
    input  logic [7:0] right_pos,
    output logic       left_fwd,
    output logic       left_rev,
    output logic       right_fwd,
    output logic       right_rev,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] steps_left
);

    localparam int unsigned ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TIMEOUT_CYCLES - TO_W'(1'b1);

    localparam logic [1:0] OP_FWD    = 2'b00;
    localparam logic [1:0] OP_REV    = 2'b01;
    localparam logic [1:0] OP_TURN_L = 2'b10;
    localparam logic [1:0] OP_TURN_R = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_SETTLE = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      steps_q, steps_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [ST_W-1:0] settle_q, settle_d;
    logic            fault_q, fault_d;
    logic [7:0]      prev_left_q;
    logic [3:0]      wheels_q, wheels_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            step_evt;
    logic            unused_right_pos;

    // Right wheel position is for monitoring only.
    assign unused_right_pos = ^right_pos;

    // Any change of the left counter is one step, including the FF->00 wrap.
    assign step_evt = (left_pos != prev_left_q);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_FWD;
            steps_q     <= 8'd0;
            to_q        <= {TO_W{1'b0}};
            settle_q    <= {ST_W{1'b0}};
            fault_q     <= 1'b0;
            prev_left_q <= 8'd0;
            wheels_q    <= 4'b0000;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            steps_q     <= steps_d;
            to_q        <= to_d;
            settle_q    <= settle_d;
            fault_q     <= fault_d;
            prev_left_q <= left_pos;
            wheels_q    <= wheels_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: abort beats a step, a step beats the stall timeout.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        steps_d  = steps_q;
        to_d     = to_q;
        settle_d = settle_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    steps_d = cmd_steps;
                    fault_d = 1'b0;
                    to_d    = {TO_W{1'b0}};
                    if (cmd_steps != 8'd0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_SETTLE;
                end else if (step_evt) begin
                    steps_d = steps_q - 8'd1;
                    to_d    = {TO_W{1'b0}};
                    if (steps_q == 8'd1) begin
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (to_q == TO_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_SETTLE;
                end else begin
                    to_d = to_q + TO_W'(1'b1);
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = {ST_W{1'b0}};
                    state_d  = S_DONE;
                end else begin
                    settle_d = settle_q + ST_W'(1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        wheels_d = 4'b0000;
        if (state_d == S_RUN) begin
            case (op_d)
                OP_FWD:    wheels_d = 4'b1010;
                OP_REV:    wheels_d = 4'b0101;
                OP_TURN_L: wheels_d = 4'b0110;
                OP_TURN_R: wheels_d = 4'b1001;
                default:   wheels_d = 4'b0000;
            endcase
        end else begin
            wheels_d = 4'b0000;
        end
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign {left_fwd, left_rev, right_fwd, right_rev} = wheels_q;
    assign busy       = busy_q;
    assign cmd_ready  = ready_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_rojobot_motion_sequencer.sv
// Directed bench for rojobot_motion_sequencer; expected done records go into a
// scoreboard queue and a monitor checks them when done pulses.
module tb_rojobot_motion_sequencer;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_steps = 8'd0;
    logic       abort = 1'b0;
    logic [7:0] left_pos = 8'd10;
    logic [7:0] right_pos = 8'd0;
    logic       left_fwd, left_rev, right_fwd, right_rev;
    logic       busy, done, fault;
    logic [7:0] steps_left;
    logic [3:0] wheels;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned cyc;
        logic        fault;
        logic [7:0]  steps;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    rojobot_motion_sequencer #(
        .SETTLE_CYCLES(S),
        .TO_W(24),
        .TIMEOUT_CYCLES(24'd50)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .abort(abort),
        .left_pos(left_pos), .right_pos(right_pos),
        .left_fwd(left_fwd), .left_rev(left_rev),
        .right_fwd(right_fwd), .right_rev(right_rev),
        .busy(busy), .done(done), .fault(fault), .steps_left(steps_left)
    );

    assign wheels = {left_fwd, left_rev, right_fwd, right_rev};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a command for one cycle; returns the cycle in which it was driven.
    task automatic issue(input logic [1:0] op, input logic [7:0] st, output int unsigned c);
        chk("ready_before_issue", cmd_ready, 1'b1);
        c = cyc;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_steps = st;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (i == bound) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_fault", {31'd0, fault}, {31'd0, mon_e.fault});
                chk("done_steps", {24'd0, steps_left}, {24'd0, mon_e.steps});
            end
        end
    end

    initial begin
        int unsigned c;
        int unsigned k;

        // Reset values
        tick(3);
        chk("rst_wheels", {28'd0, wheels}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_steps", {24'd0, steps_left}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        tick(2);

        // FWD 3 steps, left_pos 10 -> 13 every 20 cycles
        issue(2'b00, 8'd3, c);
        chk("fwd_wheels_on", {28'd0, wheels}, 32'b1010);
        chk("fwd_busy", {31'd0, busy}, 32'd1);
        chk("fwd_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("fwd_steps_load", {24'd0, steps_left}, 32'd3);
        for (int i = 1; i <= 3; i++) begin
            tick(19);
            chk("fwd_wheels_hold", {28'd0, wheels}, 32'b1010);
            left_pos = 8'(10 + i);
            c = cyc;
            if (i == 3) sb.push_back('{cyc: c + 1 + S, fault: 1'b0, steps: 8'd0});
            tick(1);
            chk("fwd_steps_dec", {24'd0, steps_left}, 32'(3 - i));
            chk("fwd_wheels_after", {28'd0, wheels}, (i < 3) ? 32'b1010 : 32'b0000);
        end
        drain(20);
        tick(1);
        chk("fwd_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("fwd_idle_busy", {31'd0, busy}, 32'd0);
        chk("fwd_fault", {31'd0, fault}, 32'd0);

        // Wrap: TURN_R 2 steps, FE -> FF -> 00
        left_pos = 8'hFE;
        tick(2);
        issue(2'b11, 8'd2, c);
        chk("wrap_wheels_on", {28'd0, wheels}, 32'b1001);
        tick(3);
        left_pos = 8'hFF;
        tick(5);
        chk("wrap_steps_1", {24'd0, steps_left}, 32'd1);
        chk("wrap_wheels_hold", {28'd0, wheels}, 32'b1001);
        left_pos = 8'h00;
        c = cyc;
        sb.push_back('{cyc: c + 1 + S, fault: 1'b0, steps: 8'd0});
        tick(1);
        chk("wrap_steps_0", {24'd0, steps_left}, 32'd0);
        chk("wrap_wheels_off", {28'd0, wheels}, 32'd0);
        drain(20);
        tick(1);
        chk("wrap_no_extra", {24'd0, steps_left}, 32'd0);

        // Zero steps, REV
        issue(2'b01, 8'd0, c);
        sb.push_back('{cyc: c + 1, fault: 1'b0, steps: 8'd0});
        chk("zero_wheels_a", {28'd0, wheels}, 32'd0);
        chk("zero_busy_a", {31'd0, busy}, 32'd1);
        chk("zero_done", {31'd0, done}, 32'd1);
        tick(1);
        chk("zero_wheels_b", {28'd0, wheels}, 32'd0);
        chk("zero_busy_b", {31'd0, busy}, 32'd0);
        chk("zero_ready", {31'd0, cmd_ready}, 32'd1);
        drain(5);

        // Stall: FWD 5, left_pos frozen at 0
        tick(1);
        issue(2'b00, 8'd5, c);
        k = c + 1;
        sb.push_back('{cyc: k + 50 + S, fault: 1'b1, steps: 8'd5});
        tick(49);
        chk("stall_wheels_hold", {28'd0, wheels}, 32'b1010);
        chk("stall_fault_pre", {31'd0, fault}, 32'd0);
        tick(1);
        chk("stall_wheels_off", {28'd0, wheels}, 32'd0);
        chk("stall_fault", {31'd0, fault}, 32'd1);
        drain(20);
        tick(2);
        chk("stall_fault_sticky", {31'd0, fault}, 32'd1);

        // Abort coinciding with a step, 4 remaining; cmd_valid while busy ignored
        issue(2'b00, 8'd5, c);
        chk("abort_fault_clr", {31'd0, fault}, 32'd0);
        tick(3);
        left_pos = 8'd1;
        tick(3);
        chk("abort_steps_4", {24'd0, steps_left}, 32'd4);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_steps = 8'd9;
        tick(2);
        cmd_valid = 1'b0;
        chk("busy_cmd_ignored_steps", {24'd0, steps_left}, 32'd4);
        chk("busy_cmd_ignored_wheels", {28'd0, wheels}, 32'b1010);
        chk("busy_ready_low", {31'd0, cmd_ready}, 32'd0);
        abort = 1'b1;
        left_pos = 8'd2;
        c = cyc;
        sb.push_back('{cyc: c + 1 + S, fault: 1'b0, steps: 8'd4});
        tick(1);
        abort = 1'b0;
        chk("abort_steps_hold", {24'd0, steps_left}, 32'd4);
        chk("abort_wheels_off", {28'd0, wheels}, 32'd0);
        chk("abort_fault", {31'd0, fault}, 32'd0);
        drain(20);
        tick(1);
        chk("abort_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset mid-RUN
        issue(2'b00, 8'd3, c);
        tick(4);
        chk("mid_wheels_on", {28'd0, wheels}, 32'b1010);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_wheels", {28'd0, wheels}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_fault", {31'd0, fault}, 32'd0);
        chk("mid_rst_steps", {24'd0, steps_left}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        tick(1);
        chk("mid_ready_after", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("mid_no_done", {31'd0, done}, 32'd0);
            tick(1);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
